// File: rtl/bayer_linebuff_flush_ctrl.sv
// Frame sequencer ahead of the 3-line Bayer line buffer. It forwards video, measures each
// frame, and appends FLUSH_LINES zero lines after the frame so the buffer can drain its bottom rows.
module bayer_linebuff_flush_ctrl #(
    parameter int C_RAM_ADDR_BITS = 11,
    parameter int C_DATA_WIDTH    = 12,
    parameter int FLUSH_LINES     = 2,
    parameter int GAP_CYCLES      = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      vs_in,
    input  logic                      hs_in,
    input  logic                      de_in,
    input  logic [C_DATA_WIDTH-1:0]   data_in,
    input  logic                      err_clr,
    output logic                      vs_out,
    output logic                      hs_out,
    output logic                      de_out,
    output logic [C_DATA_WIDTH-1:0]   data_out,
    output logic [C_RAM_ADDR_BITS:0]  line_width,
    output logic [15:0]               line_count,
    output logic                      flush_busy,
    output logic                      width_err,
    output logic                      sync_err
);
    localparam int WW = C_RAM_ADDR_BITS + 1;
    localparam int GW = $clog2(GAP_CYCLES);
    localparam logic [WW-1:0] MAX_W    = {1'b1, {C_RAM_ADDR_BITS{1'b0}}};
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
    localparam logic [1:0]    LAST_IDX = 2'(FLUSH_LINES - 1);

    typedef enum logic [2:0] {
        WAIT_VB,
        WAIT_FRAME,
        ACTIVE,
        FLUSH_GAP,
        FLUSH_LINE
    } state_t;

    state_t                  state, state_nxt;
    logic                    vs_q, de_q;
    logic                    vs_rise, vs_fall, de_rise, de_fall;
    logic [WW-1:0]           pix_cnt, pix_nxt;
    logic [WW-1:0]           cur_width, width_nxt;
    logic [WW-1:0]           flush_cnt, flush_nxt;
    logic [15:0]             line_cnt, line_nxt;
    logic [GW-1:0]           gap_cnt, gap_nxt;
    logic [1:0]              line_idx, idx_nxt;
    logic                    publish, width_set, sync_set;
    logic                    vs_d, hs_d, de_d;
    logic [C_DATA_WIDTH-1:0] data_d;

    assign vs_rise = vs_in & ~vs_q;
    assign vs_fall = ~vs_in & vs_q;
    assign de_rise = de_in & ~de_q;
    assign de_fall = ~de_in & de_q;

    // NOTE: every variable gets a default before the case so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        pix_nxt   = pix_cnt;
        line_nxt  = line_cnt;
        width_nxt = cur_width;
        gap_nxt   = gap_cnt;
        flush_nxt = flush_cnt;
        idx_nxt   = line_idx;
        publish   = 1'b0;
        width_set = 1'b0;
        sync_set  = 1'b0;

        case (state)
            WAIT_VB: begin
                if (vs_in) state_nxt = WAIT_FRAME;
            end
            WAIT_FRAME: begin
                pix_nxt   = '0;
                line_nxt  = '0;
                width_nxt = '0;
                if (vs_fall) begin
                    state_nxt = ACTIVE;
                    pix_nxt   = {{C_RAM_ADDR_BITS{1'b0}}, de_in};
                end
            end
            ACTIVE: begin
                if (!de_in)               pix_nxt   = '0;
                else if (pix_cnt == MAX_W) width_set = 1'b1;
                else                       pix_nxt   = pix_cnt + 1'b1;
                if (de_fall) begin
                    if (line_cnt != 16'hFFFF) line_nxt = line_cnt + 1'b1;
                    if (cur_width == '0)      width_nxt = pix_cnt;
                end
                if (vs_rise) begin
                    publish = 1'b1;
                    if (width_nxt != '0) begin
                        state_nxt = FLUSH_GAP;
                        gap_nxt   = '0;
                        idx_nxt   = '0;
                    end else begin
                        state_nxt = WAIT_FRAME;
                    end
                end
            end
            FLUSH_GAP, FLUSH_LINE: begin
                if (!vs_in) begin
                    // A new frame started before the flush finished: restart measurement here.
                    sync_set  = 1'b1;
                    state_nxt = ACTIVE;
                    pix_nxt   = {{C_RAM_ADDR_BITS{1'b0}}, de_in};
                    line_nxt  = '0;
                    width_nxt = '0;
                end else begin
                    sync_set = de_rise;
                    if (state == FLUSH_GAP) begin
                        gap_nxt = gap_cnt + 1'b1;
                        if (gap_cnt == GAP_LAST) begin
                            state_nxt = FLUSH_LINE;
                            flush_nxt = '0;
                        end
                    end else begin
                        flush_nxt = flush_cnt + 1'b1;
                        if (flush_cnt == line_width - 1'b1) begin
                            if (line_idx == LAST_IDX) begin
                                state_nxt = WAIT_FRAME;
                            end else begin
                                state_nxt = FLUSH_GAP;
                                gap_nxt   = '0;
                                idx_nxt   = line_idx + 1'b1;
                            end
                        end
                    end
                end
            end
            default: state_nxt = WAIT_VB;
        endcase
    end

    // Outputs follow the state being entered, so vs_out stays low from frame end through the flush.
    always_comb begin
        vs_d   = vs_in;
        hs_d   = hs_in;
        de_d   = de_in;
        data_d = data_in;
        if (state_nxt == FLUSH_GAP) begin
            vs_d   = 1'b0;
            hs_d   = 1'b1;
            de_d   = 1'b0;
            data_d = '0;
        end else if (state_nxt == FLUSH_LINE) begin
            vs_d   = 1'b0;
            hs_d   = 1'b0;
            de_d   = 1'b1;
            data_d = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= WAIT_VB;
            vs_q       <= 1'b1;
            de_q       <= 1'b0;
            pix_cnt    <= '0;
            line_cnt   <= '0;
            cur_width  <= '0;
            gap_cnt    <= '0;
            flush_cnt  <= '0;
            line_idx   <= '0;
            vs_out     <= 1'b1;
            hs_out     <= 1'b1;
            de_out     <= 1'b0;
            data_out   <= '0;
            line_width <= '0;
            line_count <= '0;
            flush_busy <= 1'b0;
            width_err  <= 1'b0;
            sync_err   <= 1'b0;
        end else begin
            state      <= state_nxt;
            vs_q       <= vs_in;
            de_q       <= de_in;
            pix_cnt    <= pix_nxt;
            line_cnt   <= line_nxt;
            cur_width  <= width_nxt;
            gap_cnt    <= gap_nxt;
            flush_cnt  <= flush_nxt;
            line_idx   <= idx_nxt;
            vs_out     <= vs_d;
            hs_out     <= hs_d;
            de_out     <= de_d;
            data_out   <= data_d;
            flush_busy <= (state_nxt == FLUSH_GAP) || (state_nxt == FLUSH_LINE);
            if (publish) begin
                line_count <= line_nxt;
                line_width <= width_nxt;
            end
            if (width_set)    width_err <= 1'b1;
            else if (err_clr) width_err <= 1'b0;
            if (sync_set)     sync_err  <= 1'b1;
            else if (err_clr) sync_err  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bayer_linebuff_flush_ctrl.sv
// Scenario bench for bayer_linebuff_flush_ctrl: passthrough scoreboard plus a queue of
// expected flush run lengths (gap, line, gap, line ...) compared against observed output runs.
module tb_bayer_linebuff_flush_ctrl;
    localparam int AB  = 11;
    localparam int DW  = 12;
    localparam int FL  = 2;
    localparam int GAP = 16;

    logic            clk = 1'b0;
    logic            reset;
    logic            vs_in, hs_in, de_in, err_clr;
    logic [DW-1:0]   data_in;
    logic            vs_out, hs_out, de_out;
    logic [DW-1:0]   data_out;
    logic [AB:0]     line_width;
    logic [15:0]     line_count;
    logic            flush_busy, width_err, sync_err;

    int              tests_run    = 0;
    int              tests_failed = 0;
    bit              pass_chk     = 1'b0;
    logic [DW+2:0]   pass_q[$];
    int              flush_q[$];

    bayer_linebuff_flush_ctrl #(
        .C_RAM_ADDR_BITS(AB),
        .C_DATA_WIDTH   (DW),
        .FLUSH_LINES    (FL),
        .GAP_CYCLES     (GAP)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .vs_in     (vs_in),
        .hs_in     (hs_in),
        .de_in     (de_in),
        .data_in   (data_in),
        .err_clr   (err_clr),
        .vs_out    (vs_out),
        .hs_out    (hs_out),
        .de_out    (de_out),
        .data_out  (data_out),
        .line_width(line_width),
        .line_count(line_count),
        .flush_busy(flush_busy),
        .width_err (width_err),
        .sync_err  (sync_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One clock of stimulus; outputs are sampled 1 time unit after the edge.
    task automatic step(input logic vs, input logic hs, input logic de, input logic [DW-1:0] d);
        logic [DW+2:0] exp_v;
        vs_in = vs; hs_in = hs; de_in = de; data_in = d;
        if (pass_chk) pass_q.push_back({vs, hs, de, d});
        @(posedge clk); #1;
        if (pass_chk && pass_q.size() > 0) begin
            exp_v = pass_q.pop_front();
            tests_run++;
            if ({vs_out, hs_out, de_out, data_out} !== exp_v) begin
                tests_failed++;
                $display("FAIL passthrough: got %h, expected %h", {vs_out, hs_out, de_out, data_out}, exp_v);
            end
        end
    endtask

    task automatic vblank(input int n);
        repeat (n) step(1'b1, 1'b0, 1'b0, '0);
    endtask

    // Lines with vs low; first_done de cycles of line 0 were already sent by the caller.
    task automatic send_lines(input int lines, input int width, input int first_done);
        for (int l = 0; l < lines; l++) begin
            if (!(l == 0 && first_done > 0)) begin
                repeat (3) step(1'b0, 1'b1, 1'b0, '0);
                repeat (3) step(1'b0, 1'b0, 1'b0, '0);
            end
            for (int p = (l == 0) ? first_done : 0; p < width; p++)
                step(1'b0, 1'b0, 1'b1, DW'($urandom));
            repeat (2) step(1'b0, 1'b0, 1'b0, '0);
        end
    endtask

    task automatic push_flush(input int width);
        for (int i = 0; i < FL; i++) begin
            flush_q.push_back(GAP);
            flush_q.push_back(width);
        end
    endtask

    // Raises vs_in and measures the masked region that follows.
    task automatic run_flush(input int exp_low, input int budget);
        int   low_cnt, busy_cnt, run_len, bad_shape, n_exp, exp_v, got;
        logic run_de;
        bit   done;
        int   runs[$];
        low_cnt = 0; busy_cnt = 0; run_len = 0; bad_shape = 0; run_de = 1'b0; done = 1'b0;
        for (int c = 0; c < budget && !done; c++) begin
            step(1'b1, 1'b0, 1'b0, '0);
            if (flush_busy === 1'b1) busy_cnt++;
            if (vs_out === 1'b0) begin
                low_cnt++;
                if (data_out !== '0 || hs_out !== ~de_out) bad_shape++;
                if (run_len != 0 && de_out !== run_de) begin
                    runs.push_back(run_len);
                    run_len = 0;
                end
                run_de = de_out;
                run_len++;
            end else if (low_cnt > 0) begin
                done = 1'b1;
            end
        end
        if (run_len != 0) runs.push_back(run_len);
        tests_run++;
        if (!done) begin tests_failed++; $display("FAIL flush_end: flush not finished within %0d cycles", budget); end
        tests_run++;
        if (low_cnt != exp_low) begin tests_failed++; $display("FAIL vs_low_len: got %0d, expected %0d", low_cnt, exp_low); end
        tests_run++;
        if (busy_cnt != exp_low) begin tests_failed++; $display("FAIL busy_len: got %0d, expected %0d", busy_cnt, exp_low); end
        tests_run++;
        if (bad_shape != 0) begin tests_failed++; $display("FAIL flush_levels: %0d bad cycles, expected 0", bad_shape); end
        n_exp = flush_q.size();
        tests_run++;
        if (runs.size() != n_exp) begin tests_failed++; $display("FAIL run_count: got %0d, expected %0d", runs.size(), n_exp); end
        while (flush_q.size() > 0) begin
            exp_v = flush_q.pop_front();
            got   = (runs.size() > 0) ? runs.pop_front() : -1;
            tests_run++;
            if (got != exp_v) begin tests_failed++; $display("FAIL run_len: got %0d, expected %0d", got, exp_v); end
        end
    endtask

    task automatic test_reset;
        reset = 1'b0; err_clr = 1'b0;
        vs_in = 1'b0; hs_in = 1'b0; de_in = 1'b0; data_in = '0;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if ({vs_out, hs_out, de_out, data_out} !== {1'b1, 1'b1, 1'b0, {DW{1'b0}}}) begin
            tests_failed++; $display("FAIL reset_video: got %h, expected %h", {vs_out, hs_out, de_out, data_out}, {1'b1, 1'b1, 1'b0, {DW{1'b0}}});
        end
        tests_run++;
        if ({line_width, line_count} !== '0) begin
            tests_failed++; $display("FAIL reset_meas: got width %0d count %0d, expected 0 0", line_width, line_count);
        end
        tests_run++;
        if ({flush_busy, width_err, sync_err} !== 3'b000) begin
            tests_failed++; $display("FAIL reset_flags: got %b, expected 000", {flush_busy, width_err, sync_err});
        end
        reset = 1'b1;
    endtask

    task automatic test_basic_frame;
        vblank(4);
        send_lines(8, 64, 0);
        push_flush(64);
        run_flush(FL * (GAP + 64), 400);
        tests_run++;
        if (line_width !== 12'd64) begin tests_failed++; $display("FAIL basic_width: got %0d, expected 64", line_width); end
        tests_run++;
        if (line_count !== 16'd8) begin tests_failed++; $display("FAIL basic_count: got %0d, expected 8", line_count); end
    endtask

    task automatic test_passthrough;
        vblank(4);
        pass_chk = 1'b1;
        send_lines(4, 40, 0);
        pass_chk = 1'b0;
        push_flush(40);
        run_flush(FL * (GAP + 40), 300);
        tests_run++;
        if (line_width !== 12'd40 || line_count !== 16'd4) begin
            tests_failed++; $display("FAIL pass_meas: got width %0d count %0d, expected 40 4", line_width, line_count);
        end
    endtask

    task automatic test_width_overflow;
        tests_run++;
        if (width_err !== 1'b0) begin tests_failed++; $display("FAIL width_err_pre: got %b, expected 0", width_err); end
        vblank(4);
        send_lines(2, 2049, 0);
        push_flush(2048);
        run_flush(FL * (GAP + 2048), 4400);
        tests_run++;
        if (width_err !== 1'b1) begin tests_failed++; $display("FAIL width_err: got %b, expected 1", width_err); end
        tests_run++;
        if (line_width !== 12'd2048) begin tests_failed++; $display("FAIL sat_width: got %0d, expected 2048", line_width); end
        tests_run++;
        if (line_count !== 16'd2) begin tests_failed++; $display("FAIL ovf_count: got %0d, expected 2", line_count); end
    endtask

    task automatic test_abort;
        vblank(4);
        send_lines(3, 24, 0);
        repeat (GAP + 11) step(1'b1, 1'b0, 1'b0, '0);
        tests_run++;
        if ({flush_busy, de_out, sync_err} !== 3'b110) begin
            tests_failed++; $display("FAIL pre_abort: got busy/de/sync %b, expected 110", {flush_busy, de_out, sync_err});
        end
        step(1'b0, 1'b0, 1'b1, 12'hABC);
        tests_run++;
        if (sync_err !== 1'b1) begin tests_failed++; $display("FAIL abort_sync_err: got %b, expected 1", sync_err); end
        tests_run++;
        if (flush_busy !== 1'b0) begin tests_failed++; $display("FAIL abort_busy: got %b, expected 0", flush_busy); end
        tests_run++;
        if ({vs_out, de_out, data_out} !== {1'b0, 1'b1, 12'hABC}) begin
            tests_failed++; $display("FAIL abort_pixel: got %h, expected %h", {vs_out, de_out, data_out}, {1'b0, 1'b1, 12'hABC});
        end
        send_lines(3, 20, 1);
        push_flush(20);
        run_flush(FL * (GAP + 20), 300);
        tests_run++;
        if (line_width !== 12'd20 || line_count !== 16'd3) begin
            tests_failed++; $display("FAIL post_abort_meas: got width %0d count %0d, expected 20 3", line_width, line_count);
        end
    endtask

    task automatic test_empty_frame_and_clear;
        int busy_cnt, low_cnt;
        busy_cnt = 0; low_cnt = 0;
        vblank(4);
        repeat (20) step(1'b0, 1'b0, 1'b0, '0);
        repeat (30) begin
            step(1'b1, 1'b0, 1'b0, '0);
            if (flush_busy !== 1'b0) busy_cnt++;
            if (vs_out !== 1'b1) low_cnt++;
        end
        tests_run++;
        if (busy_cnt != 0 || low_cnt != 0) begin
            tests_failed++; $display("FAIL empty_no_flush: got busy %0d low %0d cycles, expected 0 0", busy_cnt, low_cnt);
        end
        tests_run++;
        if (line_count !== 16'd0) begin tests_failed++; $display("FAIL empty_count: got %0d, expected 0", line_count); end
        tests_run++;
        if ({width_err, sync_err} !== 2'b11) begin tests_failed++; $display("FAIL sticky_hold: got %b, expected 11", {width_err, sync_err}); end
        err_clr = 1'b1;
        step(1'b1, 1'b0, 1'b0, '0);
        err_clr = 1'b0;
        tests_run++;
        if ({width_err, sync_err} !== 2'b00) begin tests_failed++; $display("FAIL err_clr: got %b, expected 00", {width_err, sync_err}); end
    endtask

    task automatic test_reset_mid_flush;
        int busy_cnt, low_cnt;
        busy_cnt = 0; low_cnt = 0;
        vblank(4);
        send_lines(2, 16, 0);
        repeat (6) step(1'b1, 1'b0, 1'b0, '0);
        tests_run++;
        if ({flush_busy, vs_out, de_out} !== 3'b100) begin
            tests_failed++; $display("FAIL in_gap: got busy/vs/de %b, expected 100", {flush_busy, vs_out, de_out});
        end
        #3 reset = 1'b0;
        #1;
        tests_run++;
        if ({vs_out, de_out, flush_busy} !== 3'b100) begin
            tests_failed++; $display("FAIL reset_in_gap: got vs/de/busy %b, expected 100", {vs_out, de_out, flush_busy});
        end
        repeat (2) step(1'b0, 1'b0, 1'b1, 12'h123);
        reset = 1'b1;
        send_lines(2, 16, 0);
        repeat (40) begin
            step(1'b1, 1'b0, 1'b0, '0);
            if (flush_busy !== 1'b0) busy_cnt++;
            if (vs_out !== 1'b1) low_cnt++;
        end
        tests_run++;
        if (busy_cnt != 0 || low_cnt != 0) begin
            tests_failed++; $display("FAIL partial_no_flush: got busy %0d low %0d cycles, expected 0 0", busy_cnt, low_cnt);
        end
        tests_run++;
        if (line_count !== 16'd0) begin tests_failed++; $display("FAIL partial_count: got %0d, expected 0", line_count); end
        send_lines(2, 16, 0);
        push_flush(16);
        run_flush(FL * (GAP + 16), 200);
        tests_run++;
        if (line_count !== 16'd2 || line_width !== 12'd16) begin
            tests_failed++; $display("FAIL full_after_reset: got width %0d count %0d, expected 16 2", line_width, line_count);
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_passthrough();
        test_width_overflow();
        test_abort();
        test_empty_frame_and_clear();
        test_reset_mid_flush();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
